// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Brief    : HI/LO write sequencer: MT moves, multicycle multiply, restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl #(
   parameter int MUL_STAGES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [31:0] hi_cur,
   input  logic [31:0] lo_cur,
   input  logic        flush,
   output logic        stall,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        busy
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_MUL  = 2'd1;
   localparam logic [1:0] c_ST_DIV  = 2'd2;
   localparam logic [1:0] c_ST_DONE = 2'd3;

   localparam logic [2:0] c_OP_MTLO     = 3'b101;
   localparam logic [4:0] c_DIV_LAST    = 5'd31;
   localparam logic [4:0] c_MUL_LAST    = 5'(MUL_STAGES - 1);

   logic [1:0]  r_state;
   logic [4:0]  r_cnt;
   logic        r_mt_pend;
   logic [31:0] r_hi_wdata;
   logic [31:0] r_lo_wdata;
   logic [31:0] r_opa;
   logic [31:0] r_opb;
   logic        r_signed;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic        r_neg_q;
   logic        r_neg_r;

   logic        w_legal;
   logic        w_accept;
   logic        w_accept_md;
   logic        w_is_div;
   logic        w_is_signed;
   logic        w_div_zero;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [63:0] w_a_ext;
   logic [63:0] w_b_ext;
   logic [63:0] w_prod;
   logic [32:0] w_rem_sh;
   logic [32:0] w_diff;
   logic [31:0] w_rem_nx;
   logic [31:0] w_quo_nx;

   assign w_legal     = (op <= c_OP_MTLO);
   assign w_accept    = (r_state == c_ST_IDLE) & op_valid & ~flush & w_legal;
   assign w_accept_md = w_accept & ~op[2];
   assign w_is_div    = op[1];
   assign w_is_signed = ~op[0];
   assign w_div_zero  = (src_b == 32'd0);

   // Magnitudes feed the unsigned divider core; DIVU passes operands through.
   assign w_mag_a = (w_is_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
   assign w_mag_b = (w_is_signed & src_b[31]) ? (32'd0 - src_b) : src_b;

   // Operands are stable for the whole MUL residency, so the product is a
   // multicycle path captured on the last MUL cycle.
   assign w_a_ext = {{32{r_signed & r_opa[31]}}, r_opa};
   assign w_b_ext = {{32{r_signed & r_opb[31]}}, r_opb};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_rem_sh = {r_rem, r_quo[31]};
   assign w_diff   = w_rem_sh - {1'b0, r_opb};
   assign w_rem_nx = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
   assign w_quo_nx = {r_quo[30:0], ~w_diff[32]};

   assign stall    = (w_accept_md | (r_state == c_ST_MUL) | (r_state == c_ST_DIV)) & ~flush;
   assign hilo_we  = ((r_state == c_ST_DONE) | r_mt_pend) & ~flush;
   assign hi_wdata = r_hi_wdata;
   assign lo_wdata = r_lo_wdata;
   assign busy     = (r_state != c_ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_ST_IDLE;
         r_cnt      <= 5'd0;
         r_mt_pend  <= 1'b0;
         r_hi_wdata <= 32'd0;
         r_lo_wdata <= 32'd0;
         r_opa      <= 32'd0;
         r_opb      <= 32'd0;
         r_signed   <= 1'b0;
         r_rem      <= 32'd0;
         r_quo      <= 32'd0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
      end else if (flush) begin
         r_state   <= c_ST_IDLE;
         r_cnt     <= 5'd0;
         r_mt_pend <= 1'b0;
      end else begin
         r_mt_pend <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_cnt <= 5'd0;
                  if (op[2]) begin
                     r_mt_pend  <= 1'b1;
                     r_hi_wdata <= op[0] ? hi_cur : src_a;
                     r_lo_wdata <= op[0] ? src_a  : lo_cur;
                  end else if (!w_is_div) begin
                     r_state  <= c_ST_MUL;
                     r_opa    <= src_a;
                     r_opb    <= src_b;
                     r_signed <= w_is_signed;
                  end else if (w_div_zero) begin
                     r_state    <= c_ST_DONE;
                     r_hi_wdata <= src_a;
                     r_lo_wdata <= 32'hFFFF_FFFF;
                  end else begin
                     r_state <= c_ST_DIV;
                     r_rem   <= 32'd0;
                     r_quo   <= w_mag_a;
                     r_opb   <= w_mag_b;
                     r_neg_q <= w_is_signed & (src_a[31] ^ src_b[31]);
                     r_neg_r <= w_is_signed & src_a[31];
                  end
               end
            end
            c_ST_MUL: begin
               if (r_cnt == c_MUL_LAST) begin
                  r_state    <= c_ST_DONE;
                  r_cnt      <= 5'd0;
                  r_hi_wdata <= w_prod[63:32];
                  r_lo_wdata <= w_prod[31:0];
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            c_ST_DIV: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               if (r_cnt == c_DIV_LAST) begin
                  r_state    <= c_ST_DONE;
                  r_cnt      <= 5'd0;
                  r_lo_wdata <= r_neg_q ? (32'd0 - w_quo_nx) : w_quo_nx;
                  r_hi_wdata <= r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_ctrl
// Brief    : Scoreboard bench for hilo_muldiv_ctrl with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hilo_muldiv_ctrl;

   localparam int MUL_STAGES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] hi_cur;
   logic [31:0] lo_cur;
   logic        flush;
   logic        stall;
   logic        hilo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   hilo_muldiv_ctrl #(.MUL_STAGES(MUL_STAGES)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .hi_cur   (hi_cur),
      .lo_cur   (lo_cur),
      .flush    (flush),
      .stall    (stall),
      .hilo_we  (hilo_we),
      .hi_wdata (hi_wdata),
      .lo_wdata (lo_wdata),
      .busy     (busy)
   );

   // Expected {HI, LO} straight from the architectural definition of each op.
   function automatic logic [63:0] ref_model(input logic [2:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hc,
                                             input logic [31:0] lc);
      int              sa;
      int              sb;
      longint          sp;
      longint unsigned up;
      logic [31:0]     q;
      logic [31:0]     r;
      sa = a;
      sb = b;
      case (f_op)
         3'd0: begin sp = longint'(sa) * longint'(sb); return sp; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         3'd4: return {a, lc};
         3'd5: return {hc, a};
         default: return 64'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expectation.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (hilo_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got hi=%h lo=%h, expected no write", hi_wdata, lo_wdata);
            end else begin
               e = exp_q.pop_front();
               check("hilo_data", {hi_wdata, lo_wdata}, e);
            end
         end
      end
   end

   // Presents one op at a negedge, holds it while stalled, returns at the negedge after it is consumed.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hc, input logic [31:0] lc);
      int   st_cycles;
      int   exp_cycles;
      logic md;
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      hi_cur   = hc;
      lo_cur   = lc;
      md       = (o <= 3'd3);
      if (o <= 3'd5) exp_q.push_back(ref_model(o, a, b, hc, lc));
      if (o > 3'd5 || o[2])  exp_cycles = 0;
      else if (!o[1])        exp_cycles = 1 + MUL_STAGES;
      else if (b == 32'd0)   exp_cycles = 1;
      else                   exp_cycles = 33;
      st_cycles = 0;
      for (int budget = 0; budget < 100; budget++) begin
         #1;
         if (!stall) begin
            if (md) begin
               check("done_we", {63'd0, hilo_we}, 64'd1);
               check("done_busy", {63'd0, busy}, 64'd1);
            end
            break;
         end
         st_cycles++;
         @(negedge clk);
      end
      check("stall_cycles", 64'(st_cycles), 64'(exp_cycles));
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      rst      = 1'b1;
      op_valid = 1'b0;
      op       = 3'd0;
      src_a    = 32'd0;
      src_b    = 32'd0;
      hi_cur   = 32'd0;
      lo_cur   = 32'd0;
      flush    = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {27'd0, stall, busy, hilo_we, hi_wdata[1:0], 32'd0} | {32'd0, hi_wdata | lo_wdata}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      issue(3'd4, 32'h1234_5678, 32'h0, 32'h0, 32'hAAAA_0000);
      issue(3'd0, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'h0);
      issue(3'd1, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'h0);
      issue(3'd2, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0);
      issue(3'd3, 32'd100, 32'd7, 32'h0, 32'h0);
      issue(3'd3, 32'd5, 32'd0, 32'h0, 32'h0);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
      issue(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0, 32'h0);
      issue(3'd5, 32'h0000_0001, 32'h0, 32'h5555_5555, 32'h0);
      issue(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0);

      // Illegal op and idle bus: no stall, no write
      issue(3'd6, 32'h1, 32'h2, 32'h3, 32'h4);
      issue(3'd7, 32'h1, 32'h2, 32'h3, 32'h4);
      op = 3'd4;
      repeat (3) @(negedge clk);

      // Flush mid-divide, then an MTLO right behind it
      op_valid = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_div_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      op_valid = 1'b0;
      #1;
      check("flush_div_idle", {63'd0, busy}, 64'd0);
      @(negedge clk);
      issue(3'd5, 32'h1, 32'h0, 32'h7777_0000, 32'h0);

      // Flush landing on DONE discards the result
      op_valid = 1'b1; op = 3'd1; src_a = 32'h10; src_b = 32'h20;
      repeat (1 + MUL_STAGES) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_done_we", {63'd0, hilo_we}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      op_valid = 1'b0;
      #1;
      check("flush_done_idle", {63'd0, busy}, 64'd0);

      // Flush in the same cycle as an MT op blocks acceptance
      @(negedge clk);
      op_valid = 1'b1; op = 3'd4; src_a = 32'hCAFE_F00D; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      op_valid = 1'b0;
      #1;
      check("flush_mt_we", {63'd0, hilo_we}, 64'd0);
      @(negedge clk);

      // Reset during MUL loses the op and clears outputs
      op_valid = 1'b1; op = 3'd0; src_a = 32'h3; src_b = 32'h5;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      op_valid = 1'b0;
      #1;
      check("rst_mid_mul", {29'd0, stall, busy, hilo_we, hi_wdata}, 64'd0);
      check("rst_mid_mul_lo", {32'd0, lo_wdata}, 64'd0);
      @(negedge clk);

      // Randomised back-to-back traffic with occasional gaps and corner operands
      for (int i = 0; i < 80; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         issue(ro, ra, rb, $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
